// File: rtl/vga_line_prefetch_if.sv
// Signal bundle between the VGA pixel stage, the line prefetcher and the SRAM port.
// The prefetcher uses the slave side; the VGA stage and SRAM drive the master side.
interface vga_line_prefetch_if;
   logic        line_start;
   logic [8:0]  fetch_line;
   logic [9:0]  pixel_x;
   logic        pixel_en;
   logic        pixel_data;
   logic [31:0] SRAM_data_in;
   logic        SRAM_busy;
   logic        sram_read_en;
   logic [31:0] word_address_dest;
   logic        fetch_done;
   logic        underrun;

   modport slave (
      input  line_start, fetch_line, pixel_x, pixel_en, SRAM_data_in, SRAM_busy,
      output pixel_data, sram_read_en, word_address_dest, fetch_done, underrun
   );

   modport master (
      output line_start, fetch_line, pixel_x, pixel_en, SRAM_data_in, SRAM_busy,
      input  pixel_data, sram_read_en, word_address_dest, fetch_done, underrun
   );
endinterface

// File: rtl/vga_line_prefetch.sv
// Ping-pong scanline prefetcher: loads the next line's pixels from SRAM into the back
// buffer while the VGA stage reads the current line out of the front buffer.
module vga_line_prefetch #(
   parameter int          H_ACTIVE       = 640,
   parameter int          V_ACTIVE       = 480,
   parameter int          WORDS_PER_LINE = 20,
   parameter logic [31:0] BASE_ADDR      = 32'h0
) (
   input logic               clk,
   input logic               nrst,
   vga_line_prefetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   localparam logic [4:0] LAST_IDX = 5'(WORDS_PER_LINE - 1);

   state_t      state, state_nxt;
   logic [1:0]  hold_cnt;
   logic        run;
   logic        act_sel;
   logic [1:0]  buf_vld;
   logic [8:0]  line_q;
   logic [4:0]  word_idx;
   logic        fetch_done_q;
   logic        underrun_q;
   logic        read_en;
   logic        ls;
   logic        fetch_ok;
   logic        last_word;
   logic        front_nxt;
   logic        pix_hit_p0;
   logic        pix_bit_p0;
   logic        pix_p1;
   logic [31:0] line_mem [0:1][0:WORDS_PER_LINE-1];

   // Inputs are ignored until two clocks have passed since reset release.
   assign run       = (hold_cnt == 2'd2);
   assign ls        = run && bus.line_start;
   assign fetch_ok  = ({1'b0, bus.fetch_line} < 10'(V_ACTIVE));
   assign last_word = (word_idx == LAST_IDX);
   assign front_nxt = ls ? ~act_sel : act_sel;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      read_en   = 1'b0;
      case (state)
         IDLE: state_nxt = IDLE;
         REQ: begin
            read_en = 1'b1;
            if (!bus.SRAM_busy) state_nxt = DATA;
         end
         DATA:    state_nxt = last_word ? IDLE : REQ;
         default: state_nxt = IDLE;
      endcase
      // A new line always restarts the fetch, abandoning any partial one.
      if (ls) state_nxt = fetch_ok ? REQ : IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hold_cnt     <= 2'd0;
         act_sel      <= 1'b0;
         buf_vld      <= 2'b00;
         line_q       <= 9'd0;
         word_idx     <= 5'd0;
         fetch_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         if (!run) hold_cnt <= hold_cnt + 2'd1;
         if (ls) begin
            act_sel          <= ~act_sel;
            buf_vld[act_sel] <= 1'b0;
            fetch_done_q     <= 1'b0;
            if (state != IDLE) underrun_q <= 1'b1;
            if (fetch_ok) begin
               line_q   <= bus.fetch_line;
               word_idx <= 5'd0;
            end
         end else if (state == DATA) begin
            if (last_word) begin
               buf_vld[~act_sel] <= 1'b1;
               fetch_done_q      <= 1'b1;
            end else begin
               word_idx <= word_idx + 5'd1;
            end
         end
      end
   end

   // Buffer storage carries no reset; the valid flags gate every read.
   always_ff @(posedge clk) begin
      if (state == DATA && !ls) line_mem[~act_sel][word_idx] <= bus.SRAM_data_in;
   end

   // Pixel stage p0: select from the front buffer as it will be after any swap.
   always_comb begin
      pix_hit_p0 = run && bus.pixel_en && buf_vld[front_nxt] &&
                   ({1'b0, bus.pixel_x} < 11'(H_ACTIVE));
      pix_bit_p0 = line_mem[front_nxt][bus.pixel_x[9:5]][bus.pixel_x[4:0]];
   end

   // Pixel stage p1: registered output.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) pix_p1 <= 1'b0;
      else       pix_p1 <= pix_hit_p0 & pix_bit_p0;
   end

   assign bus.pixel_data        = pix_p1;
   assign bus.sram_read_en      = read_en;
   assign bus.word_address_dest = BASE_ADDR + 32'(line_q) * 32'(WORDS_PER_LINE) + 32'(word_idx);
   assign bus.fetch_done        = fetch_done_q;
   assign bus.underrun          = underrun_q;

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch with a one-cycle-latency SRAM model.
module tb_vga_line_prefetch;
   logic tb_clk = 1'b0;
   logic nrst   = 1'b0;
   always #5 tb_clk = ~tb_clk;

   vga_line_prefetch_if bus();
   vga_line_prefetch dut (.clk(tb_clk), .nrst(nrst), .bus(bus));

   int          vectors     = 0;
   int          miscompares = 0;
   int          edge_n      = 0;
   logic        mode        = 1'b0;
   logic [31:0] sram_q      = '0;
   logic [31:0] acc_addr[$];
   int          acc_edge[$];

   assign bus.SRAM_data_in = sram_q;

   // SRAM model: mode 0 returns a walking one keyed on address, mode 1 returns AAAA_AAAA.
   always @(posedge tb_clk) begin
      edge_n <= edge_n + 1;
      if (bus.sram_read_en && !bus.SRAM_busy) begin
         sram_q <= mode ? 32'hAAAA_AAAA : (32'h1 << bus.word_address_dest[4:0]);
         acc_addr.push_back(bus.word_address_dest);
         acc_edge.push_back(edge_n);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge tb_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int t0, output int n);
      int k;
      k = 0;
      while (!bus.fetch_done && k < 200) begin
         tick();
         k++;
      end
      n = edge_n - t0;
   endtask

   initial begin
      int t0, n, k;
      bus.line_start = 1'b0;
      bus.fetch_line = '0;
      bus.pixel_x    = '0;
      bus.pixel_en   = 1'b0;
      bus.SRAM_busy  = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_read_en", bus.sram_read_en, 0);
      chk("rst_pixel", bus.pixel_data, 0);
      chk("rst_done", bus.fetch_done, 0);
      chk("rst_underrun", bus.underrun, 0);
      chk("rst_addr", bus.word_address_dest, 32'h0);
      nrst = 1'b1;
      repeat (3) tick();

      // Reads before any completed fetch are black
      bus.pixel_en = 1'b1; bus.pixel_x = 10'd1; tick();
      chk("inv_pix1", bus.pixel_data, 0);
      bus.pixel_x = 10'd8; tick();
      chk("inv_pix8", bus.pixel_data, 0);
      bus.pixel_en = 1'b0;

      // Line 2 fetch without stalls
      acc_addr.delete(); acc_edge.delete(); mode = 1'b0;
      bus.line_start = 1'b1; bus.fetch_line = 9'd2; tick();
      bus.line_start = 1'b0; t0 = edge_n;
      chk("t2_read_en", bus.sram_read_en, 1);
      chk("t2_addr0", bus.word_address_dest, 32'd40);
      wait_done(t0, n);
      chk("t2_done_cycle", n, 40);
      chk("t2_nreq", acc_addr.size(), 20);
      for (int i = 0; i < 20 && i < acc_addr.size(); i++) begin
         chk($sformatf("t2_addr%0d", i), acc_addr[i], 32'(40 + i));
         if (i > 0) chk($sformatf("t2_gap%0d", i), acc_edge[i] - acc_edge[i-1], 2);
      end

      // Line 0 fetch with a stall; same-cycle swap+pixel sees line 2
      mode = 1'b1;
      bus.line_start = 1'b1; bus.fetch_line = 9'd0; bus.pixel_en = 1'b1; bus.pixel_x = 10'd8;
      tick();
      bus.line_start = 1'b0; t0 = edge_n;
      chk("t3_swap_pix8", bus.pixel_data, 1);
      chk("t3_underrun", bus.underrun, 0);
      bus.pixel_x = 10'd9; tick();
      chk("t3_pix9", bus.pixel_data, 0);
      bus.pixel_en = 1'b0;
      k = 0;
      while (!(bus.sram_read_en && bus.word_address_dest == 32'd2) && k < 20) begin
         tick();
         k++;
      end
      chk("t3_req2", bus.word_address_dest, 32'd2);
      bus.SRAM_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t3_hold_addr%0d", i), bus.word_address_dest, 32'd2);
         chk($sformatf("t3_hold_en%0d", i), bus.sram_read_en, 1);
      end
      bus.SRAM_busy = 1'b0;
      wait_done(t0, n);
      chk("t3_done_cycle", n, 45);

      // Swap to line 0 (all AAAA_AAAA) and read pixels
      bus.line_start = 1'b1; bus.fetch_line = 9'd1; tick();
      bus.line_start = 1'b0; t0 = edge_n;
      bus.pixel_en = 1'b1;
      bus.pixel_x = 10'd0;   tick(); chk("t4_pix0", bus.pixel_data, 0);
      bus.pixel_x = 10'd1;   tick(); chk("t4_pix1", bus.pixel_data, 1);
      bus.pixel_x = 10'd639; tick(); chk("t4_pix639", bus.pixel_data, 1);
      bus.pixel_x = 10'd1; bus.pixel_en = 1'b0; tick(); chk("t4_pix_off", bus.pixel_data, 0);
      bus.pixel_en = 1'b1;
      bus.pixel_x = 10'd640; tick(); chk("t4_pix640", bus.pixel_data, 0);
      bus.pixel_x = 10'd63;  tick(); chk("t4_pix63", bus.pixel_data, 1);
      bus.pixel_en = 1'b0;
      wait_done(t0, n);
      chk("t4_done_cycle", n, 40);

      // Line 480 is out of range: swap only, no fetch
      acc_addr.delete();
      bus.line_start = 1'b1; bus.fetch_line = 9'd480; tick();
      bus.line_start = 1'b0;
      chk("t5_done_clr", bus.fetch_done, 0);
      chk("t5_read_en", bus.sram_read_en, 0);
      repeat (10) tick();
      chk("t5_nreq", acc_addr.size(), 0);
      bus.pixel_en = 1'b1; bus.pixel_x = 10'd1; tick();
      chk("t5_line1_pix1", bus.pixel_data, 1);

      // Line 5 with SRAM stuck busy; front is the unfilled 480 buffer
      bus.SRAM_busy = 1'b1;
      bus.line_start = 1'b1; bus.fetch_line = 9'd5; tick();
      bus.line_start = 1'b0;
      chk("t5_inv_front_pix", bus.pixel_data, 0);
      chk("t6_addr5", bus.word_address_dest, 32'd100);
      chk("t6_pre_underrun", bus.underrun, 0);
      repeat (3) tick();

      // Underrun: next line arrives mid-fetch
      bus.line_start = 1'b1; bus.fetch_line = 9'd6; tick();
      bus.line_start = 1'b0;
      chk("t6_underrun", bus.underrun, 1);
      chk("t6_addr6", bus.word_address_dest, 32'd120);
      chk("t6_read_en", bus.sram_read_en, 1);
      chk("t6_pix1", bus.pixel_data, 0);
      bus.pixel_x = 10'd639; tick(); chk("t6_pix639", bus.pixel_data, 0);
      bus.pixel_en = 1'b0;
      bus.SRAM_busy = 1'b0; t0 = edge_n;
      wait_done(t0, n);
      chk("t6_done", bus.fetch_done, 1);
      chk("t6_underrun_sticky", bus.underrun, 1);

      // Asynchronous reset mid-fetch, then two-cycle hold
      bus.line_start = 1'b1; bus.fetch_line = 9'd7; tick();
      bus.line_start = 1'b0;
      chk("t7_pre_read_en", bus.sram_read_en, 1);
      nrst = 1'b0; #1;
      chk("t7_rst_read_en", bus.sram_read_en, 0);
      chk("t7_rst_underrun", bus.underrun, 0);
      chk("t7_rst_addr", bus.word_address_dest, 32'h0);
      repeat (2) tick();
      nrst = 1'b1;
      bus.line_start = 1'b1; bus.fetch_line = 9'd3; tick();
      bus.line_start = 1'b0;
      chk("t7_hold1_read_en", bus.sram_read_en, 0);
      tick();
      chk("t7_hold2_read_en", bus.sram_read_en, 0);
      bus.line_start = 1'b1; bus.fetch_line = 9'd3; tick();
      bus.line_start = 1'b0;
      chk("t7_run_read_en", bus.sram_read_en, 1);
      chk("t7_run_addr", bus.word_address_dest, 32'd60);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vga_line_prefetch.md
Name: vga_line_prefetch

Overview:
- Upstream feeder for the VGA output stage.
- During each scanline it fetches the next line's 640 monochrome pixels (20 32-bit words) from SRAM into one half of a ping-pong line buffer. Meanwhile it serves the current line's pixels from the other half.
- Decouples pixel timing from SRAM_busy stalls so the VGA stage never reads SRAM directly.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- WORDS_PER_LINE, 20, 32-bit words per line (H_ACTIVE/32).
- BASE_ADDR, 32'h0, word address of line 0, pixel 0.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset; asynchronous, active-low.
- line_start  input  1  one-cycle pulse from the VGA stage at the start of each line.
- fetch_line  input  9  line index to prefetch; sampled with line_start.
- pixel_x  input  10  pixel column requested.
- pixel_en  input  1  pixel request strobe.
- pixel_data  output  1  registered pixel value.
- SRAM_data_in  input  32  SRAM read data.
- SRAM_busy  input  1  SRAM cannot accept a request this cycle.
- sram_read_en  output  1  read request.
- word_address_dest  output  32  SRAM word address.
- fetch_done  output  1  back buffer fully loaded.
- underrun  output  1  sticky: a line_start arrived before the fetch completed.

Behaviour:
- Reset values:
  - pixel_data, sram_read_en, fetch_done, underrun: 0.
  - word_address_dest: BASE_ADDR.
  - FSM: IDLE.
  - Active-buffer select: 0.
  - Both buffer-valid flags: 0.
  - Buffer contents: don't-care.
- On line_start:
  - Toggle active select. The just-filled back buffer becomes the front buffer and keeps its valid flag.
  - Clear the new back buffer's valid flag and clear fetch_done.
  - If fetch_line < V_ACTIVE: latch it, set word_idx=0, go to REQ. Otherwise go to IDLE with no fetch.
- FSM IDLE: sram_read_en=0; wait for line_start.
- FSM REQ:
  - Drive sram_read_en=1 and word_address_dest = BASE_ADDR + fetch_line*WORDS_PER_LINE + word_idx. The multiply is 32-bit unsigned.
  - Request is accepted on a cycle with sram_read_en=1 and SRAM_busy=0, then go to DATA.
  - While SRAM_busy=1, hold address and request unchanged.
- FSM DATA:
  - sram_read_en=0; capture SRAM_data_in into back buffer[word_idx]. Data is valid exactly one cycle after acceptance.
  - If word_idx == WORDS_PER_LINE-1: set the back buffer's valid flag, set fetch_done=1, go to IDLE. Otherwise increment word_idx and go to REQ.
- Fetch throughput: a fetch with no stalls takes 2*WORDS_PER_LINE = 40 cycles, well within the 800-cycle line.
- Pixel read: on a cycle with pixel_en=1, on the next cycle pixel_data = front[pixel_x[9:5]][pixel_x[4:0]]. Bit 0 of each word is the leftmost pixel of that word. pixel_data is forced to 0 when:
  - pixel_x >= H_ACTIVE, or
  - the front buffer's valid flag is 0.
- When pixel_en=0: pixel_data <= 0 next cycle.
- Underrun:
  - line_start while FSM is REQ or DATA sets underrun=1, held until reset.
  - The partial fetch is abandoned; its buffer becomes front with valid=0, so it displays black.
  - The new fetch starts immediately.
  - A DATA capture in the same cycle as line_start is discarded.
- Same-cycle line_start and pixel_en: the pixel read uses the front buffer selected after the swap.
- Reset mid-fetch: everything returns to reset values asynchronously. sram_read_en drops immediately, with no completion of the outstanding read.
- Reset values hold for 2 cycles after nrst rises.

Test Plan:
1. Reset check: nrst=0 for 2 cycles -> sram_read_en=0, pixel_data=0, fetch_done=0, underrun=0, word_address_dest=0.
2. Line fetch, no stalls:
   - Stimulus: SRAM word k = 32'h0000_0001<<(k%32); line_start with fetch_line=2, SRAM_busy=0.
   - Required: addresses 40..59 issued in order, one request every 2 cycles; fetch_done=1 at cycle 40.
3. SRAM_busy stall: busy=1 for 5 cycles on the 3rd request -> word_address_dest holds at BASE+2 and sram_read_en stays 1 for all 5 cycles; fetch_done is delayed by exactly 5 cycles.
4. Pixel read after swap:
   - Stimulus: line 0 words all 32'hAAAA_AAAA; second line_start, then pixel_en with pixel_x = 0, 1, 639, 640.
   - Required, one cycle later: pixel_data = 0, 1, 1, 0.
5. Invalid front buffer: pixel read before any completed fetch, or fetch_line=480 -> pixel_data=0 for all x; no SRAM requests for line 480.
6. Underrun: hold SRAM_busy=1 through the next line_start -> underrun=1 and stays 1; the new fetch starts at the new line's address; the displayed line reads all 0.
